// File: rtl/aes_round_ctrl.sv
// AES round sequencer: drives load / key-expansion / cipher-round strobes for
// a single-round datapath and tracks the round constant across NUM_ROUNDS rounds.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_i,
  input  logic [1:0] opcode_i,
  input  logic       hold_i,
  output logic       load_o,
  output logic       key_step_o,
  output logic       enc_step_o,
  output logic       final_round_o,
  output logic [3:0] round_o,
  output logic [7:0] r_con_o,
  output logic       busy_o,
  output logic       key_ready_o,
  output logic       cipher_ready_o,
  output logic       err_o
);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  localparam logic [1:0] OP_KEYGEN  = 2'b01;
  localparam logic [1:0] OP_ENCFULL = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;
  localparam logic [3:0] LAST_RND   = 4'(NUM_ROUNDS);

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rcon_q, rcon_d;
  logic       kr_q, kr_d;
  logic       err_q, err_d;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      cnt_q   <= 4'd0;
      rcon_q  <= 8'h00;
      kr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      rcon_q  <= rcon_d;
      kr_q    <= kr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    rcon_d         = rcon_q;
    kr_d           = kr_q;
    err_d          = 1'b0;
    load_o         = 1'b0;
    key_step_o     = 1'b0;
    enc_step_o     = 1'b0;
    final_round_o  = 1'b0;
    round_o        = 4'd0;
    r_con_o        = 8'h00;
    cipher_ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (opcode_i == OP_KEYGEN || opcode_i == OP_ENCFULL) begin
            op_d    = opcode_i;
            state_d = LOAD;
          end else if (opcode_i == OP_RSVD) begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        load_o  = 1'b1;
        kr_d    = 1'b0;
        cnt_d   = 4'd1;
        rcon_d  = 8'h01;
        state_d = ROUND;
      end
      ROUND: begin
        round_o       = cnt_q;
        r_con_o       = rcon_q;
        final_round_o = (cnt_q == LAST_RND);
        if (!hold_i) begin
          key_step_o = 1'b1;
          enc_step_o = (op_q == OP_ENCFULL);
          if (cnt_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            // xtime in GF(2^8): the key schedule's next round constant
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1B : 8'h00);
          end
        end
      end
      DONE: begin
        kr_d           = 1'b1;
        cipher_ready_o = (op_q == OP_ENCFULL);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // kr_q still reads 1 during LOAD; mask it so the level drops exactly there
  assign key_ready_o = (kr_q && state_q != LOAD) || state_q == DONE;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: default 10-round instance plus a 1-round
// instance sharing the same stimulus.
module tb_aes_round_ctrl;

  logic       clk = 1'b0;
  logic       nrst, start, hold;
  logic [1:0] opc;

  logic       load0, ks0, es0, fin0, busy0, kr0, cr0, err0;
  logic [3:0] rnd0;
  logic [7:0] rc0;
  logic       load1, ks1, es1, fin1, busy1, kr1, cr1, err1;
  logic [3:0] rnd1;
  logic [7:0] rc1;

  int checks = 0;
  int errors = 0;

  logic [7:0] rc_tab [1:10];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) u_dut (
    .clk(clk), .nrst(nrst), .start_i(start), .opcode_i(opc), .hold_i(hold),
    .load_o(load0), .key_step_o(ks0), .enc_step_o(es0), .final_round_o(fin0),
    .round_o(rnd0), .r_con_o(rc0), .busy_o(busy0), .key_ready_o(kr0),
    .cipher_ready_o(cr0), .err_o(err0)
  );

  aes_round_ctrl #(.NUM_ROUNDS(1)) u_dut1 (
    .clk(clk), .nrst(nrst), .start_i(start), .opcode_i(opc), .hold_i(hold),
    .load_o(load1), .key_step_o(ks1), .enc_step_o(es1), .final_round_o(fin1),
    .round_o(rnd1), .r_con_o(rc1), .busy_o(busy1), .key_ready_o(kr1),
    .cipher_ready_o(cr1), .err_o(err1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // advance one clock; ends at the falling edge where inputs are driven
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] idle_bus0();
    return {load0, ks0, es0, fin0, rnd0, rc0, busy0, cr0, err0};
  endfunction

  initial begin
    rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    nrst = 1'b0; start = 1'b0; hold = 1'b0; opc = 2'b00;
    tick(); tick();
    #1;
    chk("rst_bus", idle_bus0(), 32'h0);
    chk("rst_kr", {31'd0, kr0}, 32'd0);
    nrst = 1'b1;
    tick();

    // ENCFULL, no stalls, both instances
    start = 1'b1; opc = 2'b10;
    tick(); start = 1'b0; #1;
    chk("enc_load", {31'd0, load0}, 32'd1);
    chk("enc_busy1", {31'd0, busy0}, 32'd1);
    chk("enc_load_rnd", {28'd0, rnd0}, 32'd0);
    chk("enc_load_rc", {24'd0, rc0}, 32'd0);
    chk("n1_load", {31'd0, load1}, 32'd1);
    for (int r = 1; r <= 10; r++) begin
      tick(); #1;
      chk("enc_rnd", {28'd0, rnd0}, r);
      chk("enc_rc", {24'd0, rc0}, {24'd0, rc_tab[r]});
      chk("enc_steps", {30'd0, ks0, es0}, 32'd3);
      chk("enc_fin", {31'd0, fin0}, (r == 10) ? 32'd1 : 32'd0);
      chk("enc_cr_low", {31'd0, cr0}, 32'd0);
      if (r == 1) begin
        chk("n1_rnd", {28'd0, rnd1}, 32'd1);
        chk("n1_rc", {24'd0, rc1}, 32'h01);
        chk("n1_fin", {31'd0, fin1}, 32'd1);
      end
      if (r == 2) chk("n1_done", {30'd0, cr1, kr1}, 32'd3);
      if (r == 3) chk("n1_idle", {30'd0, busy1, cr1}, 32'd0);
    end
    tick(); #1;
    chk("enc_done", {29'd0, cr0, kr0, busy0}, 32'd7);
    chk("enc_done_rnd", {28'd0, rnd0}, 32'd0);
    tick();
    // back-to-back KEYGEN presented in the first IDLE cycle
    start = 1'b1; opc = 2'b01; #1;
    chk("enc_idle", {30'd0, busy0, cr0}, 32'd0);
    chk("kr_hold", {31'd0, kr0}, 32'd1);
    tick(); start = 1'b0; #1;
    chk("kg_load", {30'd0, load0, kr0}, 32'd2);
    for (int r = 1; r <= 10; r++) begin
      tick(); #1;
      chk("kg_steps", {30'd0, ks0, es0}, 32'd2);
      chk("kg_rc", {24'd0, rc0}, {24'd0, rc_tab[r]});
    end
    tick(); #1;
    chk("kg_done", {29'd0, kr0, cr0, busy0}, 32'd5);
    tick(); tick(); #1;
    chk("kg_kr_level", {30'd0, kr0, busy0}, 32'd2);

    // reserved and NOP opcodes in IDLE
    start = 1'b1; opc = 2'b11;
    tick(); start = 1'b0; #1;
    chk("err_pulse", {30'd0, err0, busy0}, 32'd2);
    tick(); #1;
    chk("err_gone", {31'd0, err0}, 32'd0);
    start = 1'b1; opc = 2'b00;
    tick(); start = 1'b0; #1;
    chk("nop", {29'd0, err0, busy0, load0}, 32'd0);

    // hold for 3 cycles in round 5; start in round 3 ignored
    start = 1'b1; opc = 2'b10;
    tick(); start = 1'b0;
    begin
      int off, done_off;
      off = 1; done_off = 0;
      while (off < 40 && done_off == 0) begin
        tick(); off++;
        start = (off == 4); opc = 2'b11;
        hold  = (off >= 6 && off <= 8);
        #1;
        if (off == 5) chk("ign_err", {31'd0, err0}, 32'd0);
        if (off == 5) chk("ign_rnd", {28'd0, rnd0}, 32'd4);
        if (off >= 6 && off <= 8) begin
          chk("hold_rnd", {28'd0, rnd0}, 32'd5);
          chk("hold_rc", {24'd0, rc0}, 32'h10);
          chk("hold_steps", {30'd0, ks0, es0}, 32'd0);
        end
        if (off == 9) chk("hold_rel", {28'd0, rnd0, 2'b00, ks0, es0}, 32'h53);
        if (cr0) done_off = off;
      end
      start = 1'b0; hold = 1'b0;
      chk("hold_done_at", done_off, 32'd15);
    end
    tick(); tick();

    // reset in round 7, then a fresh run
    start = 1'b1; opc = 2'b10;
    tick(); start = 1'b0;
    repeat (7) tick();
    #1;
    chk("pre_rst_rnd", {28'd0, rnd0}, 32'd7);
    nrst = 1'b0;
    tick(); nrst = 1'b1; #1;
    chk("rst_mid_bus", idle_bus0(), 32'h0);
    chk("rst_mid_kr", {31'd0, kr0}, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        tick(); #1;
        if (cr0 || busy0) seen = 1;
      end
      chk("rst_no_cr", seen, 32'd0);
    end
    start = 1'b1; opc = 2'b10;
    tick(); start = 1'b0;
    begin
      int off, done_off;
      off = 1; done_off = 0;
      #1;
      while (off < 40 && done_off == 0) begin
        tick(); off++; #1;
        if (cr0) done_off = off;
      end
      chk("fresh_done_at", done_off, 32'd12);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of cipher rounds sequenced; legal range 1..10.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 nrst  input  1  synchronous active-low reset.
REQ-004 start_i  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 opcode_i  input  2  operation select: 2'b00 NOP, 2'b01 KEYGEN, 2'b10 ENCFULL, 2'b11 reserved.
REQ-006 hold_i  input  1  datapath stall; freezes round sequencing while high.
REQ-007 load_o  output  1  one-cycle strobe: datapath loads key and plaintext and applies the initial AddRoundKey.
REQ-008 key_step_o  output  1  advance key expansion by one round this cycle.
REQ-009 enc_step_o  output  1  perform one cipher round this cycle.
REQ-010 final_round_o  output  1  current round is the last one; datapath skips MixColumns.
REQ-011 round_o  output  4  current round index.
REQ-012 r_con_o  output  8  round constant for the current key-expansion step.
REQ-013 busy_o  output  1  operation in progress.
REQ-014 key_ready_o  output  1  expanded key valid (level).
REQ-015 cipher_ready_o  output  1  ciphertext valid (one-cycle pulse).
REQ-016 err_o  output  1  one-cycle pulse on a rejected request.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, ROUND and DONE.
REQ-018 IDLE: start_i=1 with opcode 01 or 10 SHALL latch the opcode and go to LOAD; any other input SHALL keep the FSM in IDLE.
REQ-019 IDLE: start_i=1 with opcode 11 SHALL pulse err_o for the next cycle only and stay in IDLE; start_i=1 with opcode 00 SHALL be ignored silently.
REQ-020 LOAD (1 cycle): load_o=1, round_o=0, r_con_o=8'h00, key_ready_o cleared; next state ROUND with round counter 1.
REQ-021 ROUND, hold_i=0: key_step_o=1; enc_step_o=1 only for ENCFULL; round_o=counter; counter increments each cycle.
REQ-022 ROUND, hold_i=1: key_step_o=0, enc_step_o=0; round_o and r_con_o held; no state change.
REQ-023 r_con_o SHALL be 8'h01 in round 1; each advancing round SHALL apply xtime (shift left 1; XOR 8'h1B if the old MSB was 1), giving 01,02,04,08,10,20,40,80,1B,36.
REQ-024 final_round_o SHALL be 1 only in ROUND with round_o==NUM_ROUNDS (held through hold_i); an advancing final round SHALL go to DONE.
REQ-025 DONE (1 cycle): key_ready_o set; cipher_ready_o=1 only for ENCFULL; next state IDLE.
REQ-026 key_ready_o SHALL stay high from DONE until the next accepted start reaches LOAD.
REQ-027 busy_o SHALL be 1 exactly in LOAD, ROUND and DONE; start_i in these states SHALL be ignored with no err_o.
REQ-028 Latency with no stalls: start accepted at edge N; load_o in cycle N+1; rounds in N+2..N+NUM_ROUNDS+1; DONE in N+NUM_ROUNDS+2 (12 cycles for the default); each hold cycle SHALL add one cycle.
REQ-029 Outside ROUND: round_o=0, r_con_o=8'h00, key_step_o=enc_step_o=final_round_o=0.
REQ-030 Back-to-back: a start_i presented in the cycle after DONE SHALL be accepted (IDLE lasts a minimum of one cycle).

Reset
REQ-031 nrst=0 at a rising edge SHALL force IDLE and all outputs to 0 (key_ready_o=0, cipher_ready_o=0, err_o=0, round_o=0, r_con_o=8'h00).
REQ-032 nrst SHALL take priority over start_i and hold_i; a reset mid-operation SHALL abort it with no cipher_ready_o pulse.

Verification
REQ-033 ENCFULL with no stalls: start_i=1, opcode 10 -> load_o at +1; enc_step_o and key_step_o in +2..+11; r_con_o sequence 01..36; final_round_o at +11; cipher_ready_o and key_ready_o rising at +12; busy_o 1 for +1..+12.
REQ-034 KEYGEN: opcode 01 -> enc_step_o never high; key_step_o for 10 cycles; key_ready_o rises at +12 and holds; cipher_ready_o stays 0.
REQ-035 hold_i high for 3 cycles during round 5 -> round_o=5, r_con_o=8'h10 and steps 0 while held; DONE at +15.
REQ-036 opcode 11 in IDLE -> err_o pulse for one cycle; busy_o stays 0. start_i in round 3 -> ignored, no err_o.
REQ-037 nrst low in round 7 -> next cycle all outputs 0 and FSM in IDLE; no cipher_ready_o; a fresh ENCFULL then completes in 12 cycles.
REQ-038 NUM_ROUNDS=1 -> a single round with r_con_o=8'h01 and final_round_o=1; DONE at +3.
